stage_mem_lsu: RTL
==================

Name: stage_mem_lsu

Overview:
- Parametrised MEM pipeline stage: forwards ALU results to writeback and runs loads/stores over a req/gnt/rvalid data-memory port.
- Byte/half/word(/double) accesses with lane steering, sign/zero extension, misalignment detection and bus-error reporting.
- Sits between EX/MEM and MEM/WB; stalls upstream while a memory transaction is in flight.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- ADDR_W, 32, data-memory address width.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- valid_i  in  1  instruction present from EX/MEM.
- reg_waddr_i  in  REG_ADDR_W  destination register.
- we_i  in  1  register write enable.
- wdata_i  in  XLEN  ALU result.
- mem_op_i  in  4  operation: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LWU, 7 LD, 8 SB, 9 SH, 10 SW, 11 SD; 12-15 illegal.
- mem_addr_i  in  ADDR_W  effective address.
- mem_sdata_i  in  XLEN  store data.
- flush_i  in  1  kill the in-flight access.
- stall_o  out  1  hold EX/MEM and upstream.
- reg_waddr_o  out  REG_ADDR_W  registered writeback address.
- we_o  out  1  registered writeback enable.
- wdata_o  out  XLEN  registered writeback data.
- misalign_o  out  1  one-cycle pulse: misaligned or illegal access.
- fault_o  out  1  one-cycle pulse: bus error.
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  ADDR_W  address, aligned down to XLEN/8 bytes.
- dmem_be_o  out  XLEN/8  byte enables.
- dmem_wdata_o  out  XLEN  store data, replicated across lanes.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  response or write acknowledge.
- dmem_rdata_i  in  XLEN  read data.
- dmem_err_i  in  1  bus error; qualified by dmem_rvalid_i.

Behaviour:
- Reset (rst_n low, immediate): state IDLE; all outputs 0. Mid-transaction reset drops the request; no response is consumed.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE, valid_i, mem_op_i NONE: next edge wb outputs = inputs (1-cycle latency); stall_o 0.
- IDLE, valid_i, illegal access: misaligned (H: addr[0]; W: addr[1:0]; D: addr[2:0]), mem_op_i 12-15, or LWU/LD/SD with XLEN=32.
  - No request; stall_o 0.
  - Next edge: we_o 0, misalign_o 1 for one cycle.
- IDLE, valid_i, legal memory op: stall_o 1 combinationally.
  - Latch op, address low bits, reg_waddr_i, we_i.
  - Latch dmem_addr/be/wdata/we; go to REQ.
- REQ: dmem_req_o 1 with stable address, byte enables and data; stall_o 1.
  - dmem_gnt_i -> WAIT.
  - flush_i with no grant -> IDLE; wb we_o 0.
  - flush_i with grant in the same cycle -> DRAIN.
- WAIT: dmem_req_o 0.
  - stall_o = ~dmem_rvalid_i.
  - On dmem_rvalid_i -> IDLE; next edge writes back.
  - Load: we_o = latched we_i; wdata_o = extracted and extended data.
  - Store: we_o 0.
  - dmem_err_i: we_o 0, fault_o pulse.
  - flush_i -> DRAIN.
- DRAIN: stall_o 1. On dmem_rvalid_i, discard the response (no writeback, no fault) -> IDLE.
- Non-IDLE states ignore valid_i; upstream holds its inputs.
- Lanes: byte offset = addr[log2(XLEN/8)-1:0].
  - Byte enables = size mask shifted by offset.
  - Loads shift rdata right by 8*offset, then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU); LD is full width.
- dmem_rvalid_i while IDLE: ignored.
- While not writing back a result, we_o 0 and reg_waddr_o/wdata_o hold their values.

Test Plan:
- XLEN=32, mem_op NONE, reg 5, wdata 0x1234 -> next cycle we_o 1, reg_waddr_o 5, wdata_o 0x1234; stall_o never high.
- LB at addr 0x103, gnt same cycle, rvalid 2 cycles later, rdata 0x80FF_0000 -> dmem_be_o 4'b1000, wdata_o 0xFFFF_FF80; stall_o high from accept until the rvalid cycle.
- SH at addr 0x102, sdata 0xABCD -> dmem_be_o 4'b1100, dmem_wdata_o 0xABCD_ABCD, dmem_we_o 1; we_o 0 after ack.
- LW at addr 0x2 -> no dmem_req_o, misalign_o pulses 1 cycle, we_o 0; repeat with LD on XLEN=32 -> same.
- LHU, gnt held low 3 cycles, flush_i in cycle 2 -> IDLE without request completion; then granted request + flush in WAIT -> DRAIN, later rvalid with rdata 0xFFFF discarded, we_o 0.
- LW with rvalid+err -> fault_o pulse, we_o 0; rst_n low while in WAIT -> all outputs 0 immediately, later rvalid ignored.

Source files
------------

// File: rtl/stage_mem_lsu.sv
// stage_mem_lsu: MEM stage forwarding ALU results and running loads/stores over a req/gnt/rvalid port.
module stage_mem_lsu #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  we_i,
    input  logic [XLEN-1:0]       wdata_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [XLEN-1:0]       mem_sdata_i,
    input  logic                  flush_i,
    output logic                  stall_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic                  we_o,
    output logic [XLEN-1:0]       wdata_o,
    output logic                  misalign_o,
    output logic                  fault_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_W-1:0]     dmem_addr_o,
    output logic [XLEN/8-1:0]     dmem_be_o,
    output logic [XLEN-1:0]       dmem_wdata_o,
    input  logic                  dmem_gnt_i,
    input  logic                  dmem_rvalid_i,
    input  logic [XLEN-1:0]       dmem_rdata_i,
    input  logic                  dmem_err_i
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
    state_t state, state_nx;

    logic                  is_mem, is_load, is_signed, illegal, accept, stall, wb_fire;
    logic [3:0]            sz, szm;
    logic [15:0]           mask16;
    logic [NB-1:0]         be_nx;
    logic [XLEN-1:0]       sdata_nx;
    logic [3:0]            l_sz;
    logic                  l_load, l_sgn, l_we;
    logic [OW-1:0]         l_off;
    logic [REG_ADDR_W-1:0] l_rd;
    logic [XLEN-1:0]       sh, shl, ld_data;
    logic signed [XLEN-1:0] shs;
    logic [6:0]            amt;

    // Access size in bytes; op 0 decodes to 4 but is never treated as a memory op.
    assign sz = (mem_op_i == 4'd1 || mem_op_i == 4'd4 || mem_op_i == 4'd8) ? 4'd1 :
                (mem_op_i == 4'd2 || mem_op_i == 4'd5 || mem_op_i == 4'd9) ? 4'd2 :
                (mem_op_i == 4'd7 || mem_op_i == 4'd11) ? 4'd8 : 4'd4;
    assign szm       = sz - 4'd1;
    assign is_mem    = mem_op_i != 4'd0;
    assign is_load   = is_mem && mem_op_i <= 4'd7;
    assign is_signed = mem_op_i == 4'd1 || mem_op_i == 4'd2 || mem_op_i == 4'd3;
    assign illegal   = mem_op_i >= 4'd12 || |(mem_addr_i[2:0] & szm[2:0]) ||
                       (XLEN == 32 && (mem_op_i == 4'd6 || mem_op_i == 4'd7 || mem_op_i == 4'd11));
    assign mask16    = (16'd1 << sz) - 16'd1;
    assign be_nx     = mask16[NB-1:0] << mem_addr_i[OW-1:0];

    // Store data replicated so every lane carries the low sz bytes.
    always_comb begin
        sdata_nx = '0;
        for (int i = 0; i < NB; i++)
            sdata_nx[8*i +: 8] = mem_sdata_i[8*(i & int'(szm)) +: 8];
    end

    // Align the addressed bytes to bit 0, then extend by shifting up and back down.
    assign sh      = dmem_rdata_i >> {l_off, 3'b000};
    assign amt     = 7'(XLEN) - {l_sz, 3'b000};
    assign shl     = sh << amt;
    assign shs     = $signed(shl) >>> amt;
    assign ld_data = l_sgn ? shs : shl >> amt;

    always_comb begin
        state_nx   = state;
        stall      = 1'b0;
        accept     = 1'b0;
        dmem_req_o = 1'b0;
        case (state)
            IDLE: begin
                accept   = valid_i && is_mem && !illegal;
                stall    = accept;
                state_nx = accept ? REQ : IDLE;
            end
            REQ: begin
                dmem_req_o = 1'b1;
                stall      = 1'b1;
                state_nx   = dmem_gnt_i ? (flush_i ? DRAIN : WAIT) : (flush_i ? IDLE : REQ);
            end
            WAIT: begin
                stall    = !dmem_rvalid_i;
                // A flush coinciding with the response drops it here rather than waiting for another.
                state_nx = dmem_rvalid_i ? IDLE : (flush_i ? DRAIN : WAIT);
            end
            DRAIN: begin
                stall    = 1'b1;
                state_nx = dmem_rvalid_i ? IDLE : DRAIN;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign stall_o = rst_n && stall;
    assign wb_fire = state == WAIT && dmem_rvalid_i && !flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_waddr_o  <= '0;
            we_o         <= 1'b0;
            wdata_o      <= '0;
            misalign_o   <= 1'b0;
            fault_o      <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            l_sz         <= '0;
            l_load       <= 1'b0;
            l_sgn        <= 1'b0;
            l_we         <= 1'b0;
            l_off        <= '0;
            l_rd         <= '0;
        end else begin
            we_o       <= 1'b0;
            misalign_o <= 1'b0;
            fault_o    <= 1'b0;
            if (state == IDLE && valid_i && !is_mem) begin
                we_o        <= we_i;
                reg_waddr_o <= reg_waddr_i;
                wdata_o     <= wdata_i;
            end
            if (state == IDLE && valid_i && is_mem && illegal) misalign_o <= 1'b1;
            if (accept) begin
                l_sz         <= sz;
                l_load       <= is_load;
                l_sgn        <= is_signed;
                l_we         <= we_i;
                l_off        <= mem_addr_i[OW-1:0];
                l_rd         <= reg_waddr_i;
                dmem_we_o    <= !is_load;
                dmem_addr_o  <= {mem_addr_i[ADDR_W-1:OW], {OW{1'b0}}};
                dmem_be_o    <= be_nx;
                dmem_wdata_o <= sdata_nx;
            end
            if (wb_fire && dmem_err_i) fault_o <= 1'b1;
            if (wb_fire && !dmem_err_i && l_load) begin
                we_o        <= l_we;
                reg_waddr_o <= l_rd;
                wdata_o     <= ld_data;
            end
        end
    end
endmodule
